dram_seq: RTL



---
 rtl/dram_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_seq.sv
// dram_seq -- word-access sequencer for a multiplexed-address asynchronous DRAM.
//
// Turns a level-sensitive word request into RAS/CAS/WE strobe timing for a
// 1M x 16 DRAM. It drives a split data bus, and the top level merges
// dq_out/dq_oe onto the inout line. Optionally it issues periodic
// CAS-before-RAS refresh.
//
// Build option:
//   DRAM_SEQ_REFRESH_EN  when defined, the refresh counter, ref_pend and the
//                        RCAS/RRAS/RPRE sequence are compiled in. When it is
//                        undefined, ref_pend is tied low and access timing is
//                        unchanged.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, rnw          access request (level), 1 = read / 0 = write
//   addr[19:0]        word address: [9:0] row, [19:10] column
//   bsel[1:0]         byte select: [1] upper, [0] lower
//   wrdata[15:0]      write data
//   rddata[15:0]      registered read data
//   ack               one-clock completion pulse
//   busy              high whenever the sequencer is not idle
//   ma[9:0]           multiplexed DRAM address
//   ras_n, ucas_n, lcas_n, we_n   DRAM strobes
//   dq_out, dq_oe     write data and output enable toward the DRAM
//   dq_in             read data from the DRAM
module dram_seq #(
    parameter int RAS_CYC    = 2,
    parameter int CAS_CYC    = 2,
    parameter int PRE_CYC    = 2,
    parameter int REF_PERIOD = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rnw,
    input  logic [19:0] addr,
    input  logic [1:0]  bsel,
    input  logic [15:0] wrdata,
    output logic [15:0] rddata,
    output logic        ack,
    output logic        busy,
    output logic [9:0]  ma,
    output logic        ras_n,
    output logic        ucas_n,
    output logic        lcas_n,
    output logic        we_n,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    input  logic [15:0] dq_in
);

    typedef enum logic [2:0] {IDLE, ROW, COL, CAS, PRE, RCAS, RRAS, RPRE} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        ref_pend;
    logic        accept;

    // Request fields held for the whole access
    logic        rnw_r;
    logic [9:0]  col_r;
    logic [1:0]  bsel_r;
    logic [15:0] wrdata_r;

    assign accept = (state == IDLE) && !ref_pend && req;

`ifdef DRAM_SEQ_REFRESH_EN
    logic [15:0] ref_cnt;
    logic        ref_take;

    // The refresh sequence starts on the same edge that clears the request.
    assign ref_take = (state == IDLE) && ref_pend;

    // Free-running period counter. A wrap sets ref_pend even on the edge that
    // would clear it, so a refresh is never lost. Repeated wraps collapse into
    // one pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= 16'd0;
            ref_pend <= 1'b0;
        end else if (ref_cnt == 16'(REF_PERIOD - 1)) begin
            ref_cnt  <= 16'd0;
            ref_pend <= 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 16'd1;
            if (ref_take)
                ref_pend <= 1'b0;
        end
    end
`else
    assign ref_pend = 1'b0;
`endif

    // Request capture: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            rnw_r    <= rnw;
            col_r    <= addr[19:10];
            bsel_r   <= bsel;
            wrdata_r <= wrdata;
        end
    end

    // Sequencer. Each state sets the outputs for the next edge, so every
    // output is a register. ma changes only on edges where no strobe falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            ras_n  <= 1'b1;
            ucas_n <= 1'b1;
            lcas_n <= 1'b1;
            we_n   <= 1'b1;
            dq_oe  <= 1'b0;
            dq_out <= 16'd0;
            ma     <= 10'd0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            rddata <= 16'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (ref_pend) begin
                        // CAS-before-RAS: both CAS low while RAS is still high
                        ucas_n <= 1'b0;
                        lcas_n <= 1'b0;
                        we_n   <= 1'b1;
                        ras_n  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RCAS;
                    end else if (req) begin
                        ma    <= addr[9:0];
                        busy  <= 1'b1;
                        state <= ROW;
                    end
                end
                ROW: begin
                    ras_n <= 1'b0;
                    cnt   <= 16'(RAS_CYC - 2);
                    state <= COL;
                end
                COL: begin
                    if (cnt == 16'd0) begin
                        // Column address, WE and data settle a clock before CAS
                        ma     <= col_r;
                        we_n   <= rnw_r;
                        dq_oe  <= ~rnw_r;
                        dq_out <= wrdata_r;
                        cnt    <= 16'(CAS_CYC);
                        state  <= CAS;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CAS: begin
                    // One setup clock after COL, then CAS_CYC clocks with CAS low
                    if (cnt == 16'(CAS_CYC)) begin
                        ucas_n <= ~bsel_r[1];
                        lcas_n <= ~bsel_r[0];
                    end
                    if (cnt == 16'd0) begin
                        ras_n  <= 1'b1;
                        ucas_n <= 1'b1;
                        lcas_n <= 1'b1;
                        we_n   <= 1'b1;
                        dq_oe  <= 1'b0;
                        ack    <= 1'b1;
                        if (rnw_r && (bsel_r != 2'b00))
                            rddata <= dq_in;
                        cnt   <= 16'(PRE_CYC - 1);
                        state <= PRE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                PRE, RPRE: begin
                    if (cnt == 16'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RCAS: begin
                    ras_n <= 1'b0;
                    cnt   <= 16'(RAS_CYC + CAS_CYC - 1);
                    state <= RRAS;
                end
                RRAS: begin
                    if (cnt == 16'd0) begin
                        ras_n  <= 1'b1;
                        ucas_n <= 1'b1;
                        lcas_n <= 1'b1;
                        cnt    <= 16'(PRE_CYC - 1);
                        state  <= RPRE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
